// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline and buffered MDU results onto the register-file write port, 1-cycle latency.
// Pipeline has priority; a starvation counter forces FIFO drains; mdu_ready drops when the FIFO is full.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_valid,
  input  logic [ADDR_W-1:0]      pipe_waddr,
  input  logic [DATA_W-1:0]      pipe_wdata,
  output logic                   pipe_ready,
  input  logic                   mdu_valid,
  input  logic [ADDR_W-1:0]      mdu_waddr,
  input  logic [DATA_W-1:0]      mdu_wdata,
  output logic                   mdu_ready,
  output logic                   we,
  output logic [ADDR_W-1:0]      waddr,
  output logic [DATA_W-1:0]      wdata,
  output logic [2**ADDR_W-1:0]   pend_mask
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NREG-1:0]   pend_q, pend_d;

  logic              fifo_nempty, forced, grant_pipe, grant_fifo, granted, push, pop;
  logic [ADDR_W-1:0] gnt_addr, slot_addr;
  logic [DATA_W-1:0] gnt_data;
  logic [PTR_W-1:0]  ofs;

  assign fifo_nempty = (count_q != '0);
  assign forced      = fifo_nempty && (starve_q == STARVE_C);
  assign mdu_ready   = (count_q < DEPTH_C);
  assign push        = mdu_valid && mdu_ready;

  always_comb begin
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    pipe_ready = 1'b1;
    if (forced) begin
      grant_fifo = 1'b1;
      pipe_ready = 1'b0;
    end else if (pipe_valid) begin
      grant_pipe = 1'b1;
    end else if (fifo_nempty) begin
      grant_fifo = 1'b1;
    end
  end

  assign pop      = grant_fifo;
  assign granted  = grant_pipe || grant_fifo;
  assign gnt_addr = grant_fifo ? fifo_addr_q[rd_ptr_q] : pipe_waddr;
  assign gnt_data = grant_fifo ? fifo_data_q[rd_ptr_q] : pipe_wdata;

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d  = starve_q;
    slot_addr = '0;
    ofs       = '0;
    if (pop || !fifo_nempty) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q != STARVE_C)) begin
      starve_d = starve_q + SC_W'(1);
    end
    // Mask reflects the FIFO as it will stand after this edge, so a pop clears its bit with the write.
    pend_d = '0;
    for (int s = 0; s < FIFO_DEPTH; s++) begin
      slot_addr = (push && (wr_ptr_q == PTR_W'(s))) ? mdu_waddr : fifo_addr_q[s];
      ofs       = PTR_W'(s) - rd_ptr_d;
      if (CNT_W'(ofs) < count_d) pend_d[slot_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < FIFO_DEPTH; s++) begin
        fifo_addr_q[s] <= '0;
        fifo_data_q[s] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= mdu_waddr;
        fifo_data_q[wr_ptr_q] <= mdu_wdata;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= granted && (gnt_addr != '0);
      if (granted) begin
        waddr_q <= gnt_addr;
        wdata_q <= gnt_data;
      end
      pend_q   <= pend_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign pend_mask = pend_q;
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back stage that sits directly upstream of the register file and drives its write port (we, waddr, wdata).
- Merges two result sources: the in-order pipeline (ALU/MEM) and the long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO; the pipeline normally has priority, and a starvation counter forces FIFO drains.
- Exposes a pending-write mask so hazard logic can stall readers of registers that are still queued.

Parameters:
- DATA_W, 32, write-data width
- ADDR_W, 5, register address width (32 registers)
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, number of consecutive pipe grants with a non-empty FIFO before a drain is forced

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- pipe_valid  in  1  pipeline result present
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline result
- pipe_ready  out  1  pipeline result accepted this cycle (combinational)
- mdu_valid  in  1  MDU result present
- mdu_waddr  in  ADDR_W  MDU destination register
- mdu_wdata  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept (combinational)
- we  out  1  register-file write enable (registered)
- waddr  out  ADDR_W  register-file write address (registered)
- wdata  out  DATA_W  register-file write data (registered)
- pend_mask  out  2**ADDR_W  bit i = 1 when a FIFO entry targets register i (registered state)

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock edge needed):
  - we=0, waddr=0, wdata=0.
  - FIFO emptied; count, rd_ptr and wr_ptr = 0.
  - starve_cnt=0; pend_mask=0.
  - Combinational outputs during reset: pipe_ready=1, mdu_ready=1.
- Any entries in flight when reset asserts mid-operation are discarded; there is no replay.
- FIFO push: mdu_valid & mdu_ready.
  - mdu_ready = (count < FIFO_DEPTH).
  - A pop in the same cycle does not raise mdu_ready; there is no fall-through path.
- Grant select, evaluated each cycle with forced = (count != 0) & (starve_cnt == STARVE_MAX):
  - forced → grant FIFO head; pipe_ready=0.
  - else pipe_valid → grant pipe; pipe_ready=1.
  - else count != 0 → grant FIFO head; pipe_ready=1, since the pipe is idle.
  - else no grant; pipe_ready=1.
- Output register, updated on the next edge after a grant (latency 1 cycle):
  - waddr and wdata take the granted entry.
  - we = granted & (granted waddr != 0). Writes to r0 are consumed but suppressed.
  - With no grant: we=0 and waddr/wdata hold their previous values.
- starve_cnt:
  - Cleared when the FIFO pops or count == 0.
  - Otherwise incremented on each pipe grant, saturating at STARVE_MAX.
- Simultaneous push and pop: count unchanged and both pointers advance modulo FIFO_DEPTH. Pointer wrap is transparent.
- FIFO contents:
  - The FIFO pops strictly in order.
  - A push while full cannot occur, because mdu_ready=0; mdu_valid held high keeps its data stable.
- pend_mask:
  - Recomputed from the valid FIFO entries after each edge.
  - Register 0 is never set.
  - Duplicate addresses are ORed.
  - A popped entry's bit clears in the same edge that loads the output register.
- WAW ordering between pipe and MDU to the same register is guaranteed upstream by the hazard unit, which uses pend_mask; this block does not reorder or check for it.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, rst_n low mid-cycle → immediately we=0, pend_mask=0, mdu_ready=1. After release, no stale write appears.
- Pipe only: pipe_valid, waddr=8, wdata=0xDEADBEEF → next cycle we=1, waddr=8, wdata=0xDEADBEEF; pipe_ready=1 throughout.
- Starvation: push MDU waddr=12, wdata=0x00001234 while pipe_valid is continuous → pend_mask[12]=1 for 4 pipe grants. On the 5th cycle pipe_ready=0, then we=1, waddr=12, wdata=0x1234; pend_mask=0 and pipe resumes.
- FIFO full: 3 back-to-back MDU results under continuous pipe traffic → mdu_ready=0 after 2 pushes, third held until the forced drain. Data emerges in push order.
- r0 suppression: pipe waddr=0, wdata=0xFFFFFFFF → pipe_ready=1, next cycle we=0. MDU waddr=0 → pend_mask stays 0.
- Simultaneous push/pop: count=1, pipe idle, mdu_valid → head written (we=1), count stays 1, pointers wrap correctly over 4 consecutive iterations.
